// File: rtl/fm_pkg.sv
// fm_pkg: shared types for the program-counter sequencer
package fm_pkg;
    localparam int PC_W_DEFAULT = 8;
    typedef logic [PC_W_DEFAULT-1:0] pc_t;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} seq_state_t;
endpackage

// File: rtl/pc_stack.sv
// pc_stack: LIFO return-address stack; push when full and pop when empty are dropped
module pc_stack #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] wr_idx, top_idx;
    assign wr_idx = AW'(cnt);
    assign top_idx = AW'(cnt - 1'b1);
    assign full = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign dout = mem[top_idx];
    // entry storage, written at the current fill level
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_idx] <= din;
    end
    // fill level; reset empties the stack
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (push && !full)
            cnt <= cnt + 1'b1;
        else if (pop && !empty)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/RUN/HALTED program counter; optional return stack under PC_STACK_EN
module pc_sequencer
    import fm_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            halt,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            branch_en,
    input  logic [7:0]      branch_off,
    input  logic            call_en,
    input  logic            ret_en,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic            stack_err
);
    seq_state_t state, state_next;
    logic [PC_W-1:0] pc_next, pc_inc, pc_br;
    assign pc_inc = pc + PC_W'(1);
    assign pc_br = pc + PC_W'($signed(branch_off));
`ifdef PC_STACK_EN
    logic push, pop, full, empty, err_set;
    logic [PC_W-1:0] dout;
    pc_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(pc_inc),
        .dout(dout),
        .full(full),
        .empty(empty)
    );
    // sticky stack fault, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            stack_err <= 1'b0;
        else if (err_set)
            stack_err <= 1'b1;
    end
`else
    logic unused_ctl;
    assign unused_ctl = call_en | ret_en | (STACK_DEPTH == 0);
    assign stack_err = 1'b0;
`endif
    // state, pc and status flags all registered; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_next;
            pc <= pc_next;
            busy <= state_next == RUN;
            done <= state_next == HALTED;
        end
    end
    // start launches from IDLE or HALTED; halt is the only way out of RUN
    always_comb begin
        state_next = (state == RUN) ? (halt ? HALTED : RUN) : (start ? RUN : state);
    end
    // one pc action per cycle in fixed priority; controls other than start only act in RUN
    always_comb begin
        pc_next = pc;
`ifdef PC_STACK_EN
        push = 1'b0;
        pop = 1'b0;
        err_set = 1'b0;
`endif
        if (state != RUN)
            pc_next = start ? start_addr : pc;
        else if (halt || stall)
            pc_next = pc;
`ifdef PC_STACK_EN
        else if (call_en) begin
            pc_next = jump_addr;
            push = !full;
            err_set = full;
        end else if (ret_en) begin
            pc_next = empty ? pc_inc : dout;
            pop = !empty;
            err_set = empty;
        end
`endif
        else if (jump_en)
            pc_next = jump_addr;
        else if (branch_en)
            pc_next = pc_br;
        else
            pc_next = pc_inc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the pc sequencer, stack scenarios under PC_STACK_EN
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [7:0] start_addr = '0;
    logic halt = 1'b0;
    logic stall = 1'b0;
    logic jump_en = 1'b0;
    logic [7:0] jump_addr = '0;
    logic branch_en = 1'b0;
    logic [7:0] branch_off = '0;
    logic call_en = 1'b0;
    logic ret_en = 1'b0;
    logic [7:0] pc;
    logic busy, done, stack_err;
    int total = 0;
    int bad = 0;

    pc_sequencer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .halt(halt),
        .stall(stall),
        .jump_en(jump_en),
        .jump_addr(jump_addr),
        .branch_en(branch_en),
        .branch_off(branch_off),
        .call_en(call_en),
        .ret_en(ret_en),
        .pc(pc),
        .busy(busy),
        .done(done),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task start_at(input logic [7:0] a);
        start = 1'b1;
        start_addr = a;
        tick;
        start = 1'b0;
    endtask

    task test_reset;
        tick;
        reset = 1'b0;
        total++;
        if ({pc, busy, done, stack_err} !== {8'h00, 3'b000}) begin
            bad++;
            $display("FAIL reset_state got pc=%h busy=%b done=%b err=%b want pc=00 busy=0 done=0 err=0", pc, busy, done, stack_err);
        end
        jump_en = 1'b1;
        jump_addr = 8'h33;
        tick;
        jump_en = 1'b0;
        total++;
        if ({pc, busy} !== {8'h00, 1'b0}) begin
            bad++;
            $display("FAIL idle_hold got pc=%h busy=%b want pc=00 busy=0", pc, busy);
        end
    endtask

    task test_sequential;
        do_reset;
        start_at(8'h10);
        total++;
        if ({pc, busy, done} !== {8'h10, 2'b10}) begin
            bad++;
            $display("FAIL start_load got pc=%h busy=%b done=%b want pc=10 busy=1 done=0", pc, busy, done);
        end
        start = 1'b1;
        start_addr = 8'h77;
        tick;
        start = 1'b0;
        total++;
        if (pc !== 8'h11) begin
            bad++;
            $display("FAIL inc_start_ignored got pc=%h want 11", pc);
        end
        tick;
        total++;
        if ({pc, busy} !== {8'h12, 1'b1}) begin
            bad++;
            $display("FAIL inc_second got pc=%h busy=%b want pc=12 busy=1", pc, busy);
        end
    endtask

    task test_branch_wrap;
        do_reset;
        start_at(8'h05);
        branch_en = 1'b1;
        branch_off = 8'hFB;
        tick;
        total++;
        if (pc !== 8'h00) begin
            bad++;
            $display("FAIL branch_back got pc=%h want 00", pc);
        end
        branch_off = 8'h05;
        tick;
        branch_en = 1'b0;
        total++;
        if (pc !== 8'h05) begin
            bad++;
            $display("FAIL branch_fwd got pc=%h want 05", pc);
        end
        jump_en = 1'b1;
        jump_addr = 8'hFF;
        branch_en = 1'b1;
        tick;
        jump_en = 1'b0;
        branch_en = 1'b0;
        total++;
        if (pc !== 8'hFF) begin
            bad++;
            $display("FAIL jump_over_branch got pc=%h want ff", pc);
        end
        tick;
        total++;
        if (pc !== 8'h00) begin
            bad++;
            $display("FAIL inc_wrap got pc=%h want 00", pc);
        end
    endtask

    task test_halt_restart;
        do_reset;
        start_at(8'h20);
        halt = 1'b1;
        jump_en = 1'b1;
        jump_addr = 8'h99;
        tick;
        halt = 1'b0;
        total++;
        if ({pc, busy, done} !== {8'h20, 2'b01}) begin
            bad++;
            $display("FAIL halt got pc=%h busy=%b done=%b want pc=20 busy=0 done=1", pc, busy, done);
        end
        tick;
        jump_en = 1'b0;
        total++;
        if ({pc, done} !== {8'h20, 1'b1}) begin
            bad++;
            $display("FAIL halted_hold got pc=%h done=%b want pc=20 done=1", pc, done);
        end
        start_at(8'h00);
        total++;
        if ({pc, busy, done} !== {8'h00, 2'b10}) begin
            bad++;
            $display("FAIL restart got pc=%h busy=%b done=%b want pc=00 busy=1 done=0", pc, busy, done);
        end
    endtask

    task test_stall_reset;
        do_reset;
        start_at(8'h30);
        stall = 1'b1;
        branch_en = 1'b1;
        branch_off = 8'h10;
        tick;
        stall = 1'b0;
        branch_en = 1'b0;
        total++;
        if (pc !== 8'h30) begin
            bad++;
            $display("FAIL stall got pc=%h want 30", pc);
        end
        tick;
        total++;
        if (pc !== 8'h31) begin
            bad++;
            $display("FAIL after_stall got pc=%h want 31", pc);
        end
        reset = 1'b1;
        start = 1'b1;
        start_addr = 8'h44;
        jump_en = 1'b1;
        jump_addr = 8'h55;
        tick;
        reset = 1'b0;
        start = 1'b0;
        total++;
        if ({pc, busy, done} !== {8'h00, 2'b00}) begin
            bad++;
            $display("FAIL reset_mid_run got pc=%h busy=%b done=%b want pc=00 busy=0 done=0", pc, busy, done);
        end
        tick;
        jump_en = 1'b0;
        total++;
        if ({pc, busy} !== {8'h00, 1'b0}) begin
            bad++;
            $display("FAIL idle_after_reset got pc=%h busy=%b want pc=00 busy=0", pc, busy);
        end
    endtask

`ifdef PC_STACK_EN
    task test_stack;
        do_reset;
        start_at(8'h40);
        call_en = 1'b1;
        jump_addr = 8'h80;
        tick;
        call_en = 1'b0;
        total++;
        if (pc !== 8'h80) begin
            bad++;
            $display("FAIL call got pc=%h want 80", pc);
        end
        ret_en = 1'b1;
        tick;
        ret_en = 1'b0;
        total++;
        if ({pc, stack_err} !== {8'h41, 1'b0}) begin
            bad++;
            $display("FAIL ret got pc=%h err=%b want pc=41 err=0", pc, stack_err);
        end
        call_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            jump_addr = 8'hA0 + 8'(i);
            tick;
        end
        total++;
        if ({pc, stack_err} !== {8'hA3, 1'b0}) begin
            bad++;
            $display("FAIL four_calls got pc=%h err=%b want pc=a3 err=0", pc, stack_err);
        end
        jump_addr = 8'hA4;
        tick;
        call_en = 1'b0;
        total++;
        if ({pc, stack_err} !== {8'hA4, 1'b1}) begin
            bad++;
            $display("FAIL overflow got pc=%h err=%b want pc=a4 err=1", pc, stack_err);
        end
        ret_en = 1'b1;
        tick;
        ret_en = 1'b0;
        total++;
        if ({pc, stack_err} !== {8'hA3, 1'b1}) begin
            bad++;
            $display("FAIL ret_after_overflow got pc=%h err=%b want pc=a3 err=1", pc, stack_err);
        end
    endtask

    task test_underflow;
        do_reset;
        start_at(8'h50);
        total++;
        if (stack_err !== 1'b0) begin
            bad++;
            $display("FAIL err_cleared got err=%b want 0", stack_err);
        end
        ret_en = 1'b1;
        tick;
        ret_en = 1'b0;
        total++;
        if ({pc, stack_err} !== {8'h51, 1'b1}) begin
            bad++;
            $display("FAIL underflow got pc=%h err=%b want pc=51 err=1", pc, stack_err);
        end
        tick;
        total++;
        if ({pc, stack_err} !== {8'h52, 1'b1}) begin
            bad++;
            $display("FAIL err_sticky got pc=%h err=%b want pc=52 err=1", pc, stack_err);
        end
    endtask
`else
    task test_no_stack;
        do_reset;
        start_at(8'h40);
        call_en = 1'b1;
        jump_addr = 8'h80;
        tick;
        call_en = 1'b0;
        total++;
        if (pc !== 8'h41) begin
            bad++;
            $display("FAIL call_ignored got pc=%h want 41", pc);
        end
        ret_en = 1'b1;
        tick;
        ret_en = 1'b0;
        total++;
        if ({pc, stack_err} !== {8'h42, 1'b0}) begin
            bad++;
            $display("FAIL ret_ignored got pc=%h err=%b want pc=42 err=0", pc, stack_err);
        end
        call_en = 1'b1;
        jump_en = 1'b1;
        tick;
        call_en = 1'b0;
        jump_en = 1'b0;
        total++;
        if (pc !== 8'h80) begin
            bad++;
            $display("FAIL call_falls_to_jump got pc=%h want 80", pc);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_sequential;
        test_branch_wrap;
        test_halt_restart;
        test_stall_reset;
`ifdef PC_STACK_EN
        test_stack;
        test_underflow;
`else
        test_no_stack;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (used only with PC_STACK_EN).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begin execution at start_addr.
REQ-006 start_addr  input  PC_W  first instruction address.
REQ-007 halt  input  1  stop request from the halt detector, combinational on pc.
REQ-008 stall  input  1  hold pc this cycle.
REQ-009 jump_en  input  1  absolute jump request.
REQ-010 jump_addr  input  PC_W  absolute target; also the call target.
REQ-011 branch_en  input  1  relative branch request.
REQ-012 branch_off  input  8  signed two's-complement branch offset.
REQ-013 call_en  input  1  subroutine call request.
REQ-014 ret_en  input  1  subroutine return request.
REQ-015 pc  output  PC_W  current instruction address.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  high in HALTED.
REQ-018 stack_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-019 SHALL implement FSM IDLE, RUN, HALTED, with pc, busy and done registered.
REQ-020 In IDLE, start=1 SHALL load pc<=start_addr and enter RUN next cycle; otherwise pc holds.
REQ-021 In RUN, one action SHALL apply per cycle, in priority order: halt, stall, call, ret, jump, branch, increment.
REQ-022 halt=1 in RUN SHALL hold pc and enter HALTED, so done=1 and busy=0 from the next cycle.
REQ-023 stall=1 SHALL hold pc for that cycle.
REQ-024 jump SHALL load pc<=jump_addr.
REQ-025 branch SHALL load pc<=pc+sign_extend(branch_off), modulo 2^PC_W.
REQ-026 increment SHALL load pc<=pc+1, with wrap from 2^PC_W-1 to 0.
REQ-027 All pc updates SHALL take effect exactly one cycle after the qualifying inputs.
REQ-028 start SHALL be ignored in RUN.
REQ-029 In HALTED, pc and done SHALL hold; start=1 SHALL reload start_addr, clear done and enter RUN.
REQ-030 Control inputs other than start SHALL be ignored outside RUN.

Reset
REQ-031 reset SHALL force IDLE, pc=0, busy=0, done=0, stack_err=0 and an empty stack, and SHALL override all other inputs in the same cycle, including mid-RUN.

Configuration
REQ-032 With macro PC_STACK_EN defined:
- call SHALL push pc+1 and load pc<=jump_addr.
- ret SHALL load pc<=popped entry.
- push when STACK_DEPTH entries are full SHALL drop the push, still jump, and set stack_err.
- pop when empty SHALL increment pc and set stack_err.
- stack_err SHALL clear only on reset.
REQ-033 Without PC_STACK_EN:
- call_en and ret_en SHALL be ignored, so increment applies.
- stack_err SHALL be tied 0.
- no stack storage SHALL be synthesized.

Structure
REQ-034 Shared package fm_pkg SHALL hold the pc_t typedef (PC_W bits), the seq_state_t enum (IDLE/RUN/HALTED) and the default PC_W.
REQ-035 The return stack SHALL be sub-module pc_stack (push, pop, din, dout, full, empty), instantiated only under PC_STACK_EN.

Verification
REQ-036 The bench SHALL cover: reset, start with start_addr=8'h10, no controls -> pc 10,11,12 on successive cycles, busy=1.
REQ-037 The bench SHALL cover: pc=8'h05, branch_off=8'hFB -> pc=8'h00 next cycle; pc=8'hFF and increment -> pc=8'h00.
REQ-038 The bench SHALL cover: halt asserted at pc=8'h20 with jump_en=1 -> pc stays 8'h20, done=1 next cycle; then start with start_addr=8'h00 -> RUN, done=0.
REQ-039 The bench SHALL cover: stall with branch_en both high at pc=8'h30 -> pc=8'h30; reset mid-RUN -> pc=0, IDLE.
REQ-040 The bench SHALL cover, with PC_STACK_EN: call at pc=8'h40 to 8'h80, then ret -> pc=8'h41; five calls with depth 4 -> stack_err=1.
REQ-041 The bench SHALL cover, with PC_STACK_EN: ret on empty stack at pc=8'h50 -> pc=8'h51, stack_err=1.
